// File: rtl/store_narrower_pkg.sv
// Shared types and helpers for the store narrower: transfer sizes, FSM states
// and the size-to-beat-count mapping.
package store_narrower_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Number of byte beats needed to emit a store of the given size.
    function automatic logic [IDX_W:0] beat_count(input size_e size);
        logic [IDX_W:0] n;
        case (size)
            SZ_BYTE: n = 4'd1;
            SZ_HALF: n = 4'd2;
            SZ_WORD: n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fit_checker.sv
// Flags whether a register-form value survives truncation to the store width,
// i.e. re-sign-extending the narrow field reproduces the full 64-bit value.
module fit_checker
    import store_narrower_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        size,
    output logic              fits
);

    logic [DATA_W-1:0] ext_c;

    always_comb begin
        ext_c = value;
        case (size_e'(size))
            SZ_BYTE: ext_c = {{56{value[7]}},  value[7:0]};
            SZ_HALF: ext_c = {{48{value[15]}}, value[15:0]};
            SZ_WORD: ext_c = {{32{value[31]}}, value[31:0]};
            default: ext_c = value;
        endcase
        fits = (ext_c == value);
    end

endmodule

// File: rtl/store_narrower.sv
// Splits a 1/2/4/8-byte store into little-endian byte beats with a
// valid/ready handshake, reporting whether the value fits the chosen width.
module store_narrower
    import store_narrower_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              fits
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    size_e             size_q,  size_d;
    logic              fits_q,  fits_d;
    logic              rdy_q,   rdy_d;

    logic              fits_c;
    logic              accept_c;
    logic [IDX_W-1:0]  last_idx_c;

    fit_checker u_fit_checker (
        .value (in_data),
        .size  (in_size),
        .fits  (fits_c)
    );

    // Reset release is taken through one flop so acceptance waits an extra edge.
    assign rdy_d = 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        base_d     = base_q;
        size_d     = size_q;
        fits_d     = fits_q;

        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_SEND);
        last_idx_c = IDX_W'(beat_count(size_q) - 4'd1);
        out_byte   = data_q[{idx_q, 3'b000} +: BYTE_W];
        out_addr   = base_q + ADDR_W'(idx_q);
        out_last   = (idx_q == last_idx_c);
        fits       = fits_q;
        accept_c   = in_valid && (state_q == ST_IDLE) && rdy_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    data_d  = in_data;
                    base_d  = in_addr;
                    size_d  = size_e'(in_size);
                    fits_d  = fits_c;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            base_q  <= '0;
            size_q  <= SZ_BYTE;
            fits_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            base_q  <= base_d;
            size_q  <= size_d;
            fits_q  <= fits_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_store_narrower.sv
// Randomised and directed bench for store_narrower against a queue-based
// model of the byte beats each accepted store must produce.
module tb_store_narrower;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_addr;
    logic [1:0]  in_size;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [63:0] out_addr;
    logic        out_last;
    logic        fits;

    int checks   = 0;
    int failures = 0;

    store_narrower #(.ADDR_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .fits      (fits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sign-extend the low 8*n bits of d to 64 bits using arithmetic shifts.
    function automatic logic [63:0] sext(input logic [63:0] d, input int n);
        int sh;
        logic signed [63:0] t;
        sh = 64 - 8 * n;
        t  = d << sh;
        t  = t >>> sh;
        return 64'(t);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0]  b;
        logic [63:0] a;
        logic        l;
    } beat_t;

    beat_t mq[$];
    beat_t hd;
    logic  m_fits = 1'b0;
    int    rel    = 0;
    int    nbeats;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_fits = 1'b0;
            rel    = 0;
        end else begin
            if (mq.size() != 0) begin
                if (out_ready) hd = mq.pop_front();
            end else if (in_valid && rel >= 1) begin
                nbeats = 1 << in_size;
                for (int i = 0; i < nbeats; i++) begin
                    hd.b = 8'((in_data >> (8 * i)) & 64'hFF);
                    hd.a = in_addr + 64'(i);
                    hd.l = (i == nbeats - 1);
                    mq.push_back(hd);
                end
                m_fits = (sext(in_data, nbeats) == in_data);
            end
            if (rel < 2) rel++;
        end
        #1;
        chk("in_ready", 64'(in_ready), 64'(mq.size() == 0));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("fits", 64'(fits), 64'(m_fits));
        if (mq.size() != 0 && out_valid === 1'b1) begin
            chk("out_byte", 64'(out_byte), 64'(mq[0].b));
            chk("out_addr", out_addr, mq[0].a);
            chk("out_last", 64'(out_last), 64'(mq[0].l));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [63:0] d, input logic [63:0] a, input logic [1:0] s);
        int t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        in_size  = s;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic beat(input string name, input logic [7:0] b, input logic [63:0] a, input logic l);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_byte"}, 64'(out_byte), 64'(b));
        chk({name, "_addr"}, out_addr, a);
        chk({name, "_last"}, 64'(out_last), 64'(l));
    endtask

    logic [7:0]  wb [4];
    int          acc [$];
    int          hold;
    logic [63:0] d;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        in_size   = '0;
        out_ready = 1'b1;
        wb        = '{8'h78, 8'h56, 8'h34, 8'h12};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fits", 64'(fits), 64'd0);

        // Request pending at release must not be taken on the first edge.
        in_valid = 1'b1;
        in_size  = 2'd0;
        in_data  = 64'h55;
        reset    = 1'b1;
        @(posedge clk);
        #1 chk("sync_no_early_accept", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Byte store, negative value.
        send(64'hFFFF_FFFF_FFFF_FF80, 64'h100, 2'd0);
        beat("byte", 8'h80, 64'h100, 1'b1);
        chk("byte_fits", 64'(fits), 64'd1);
        @(negedge clk);

        // Word store, four little-endian beats.
        send(64'h0000_0000_1234_5678, 64'h20, 2'd2);
        for (int i = 0; i < 4; i++) begin
            beat("word", wb[i], 64'h20 + 64'(i), i == 3);
            chk("word_fits", 64'(fits), 64'd1);
            @(negedge clk);
        end

        // Positive byte that overflows.
        send(64'h80, 64'h200, 2'd0);
        beat("ovf", 8'h80, 64'h200, 1'b1);
        chk("ovf_fits", 64'(fits), 64'd0);
        @(negedge clk);

        // Half store stalled for three edges, then wrapping to address zero.
        out_ready = 1'b0;
        send(64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1);
        for (int k = 0; k < 4; k++) begin
            beat("hold", 8'hCD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
            if (k == 3) out_ready = 1'b1;
            @(negedge clk);
        end
        beat("wrap", 8'hAB, 64'h0, 1'b1);
        chk("wrap_fits", 64'(fits), 64'd0);
        @(negedge clk);

        // Reset during beat index 3 of a double store.
        send(64'h0807_0605_0403_0201, 64'h40, 2'd3);
        for (int i = 0; i < 3; i++) begin
            beat("dbl", 8'(i + 1), 64'h40 + 64'(i), 1'b0);
            @(negedge clk);
        end
        beat("dbl3", 8'h04, 64'h43, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_fits", 64'(fits), 64'd0);
        @(negedge clk);
        chk("midrst_out_valid2", 64'(out_valid), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_beat", 64'(out_valid), 64'd0);
        end

        // Back-to-back byte requests with in_valid held high.
        in_size  = 2'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (in_ready === 1'b1) acc.push_back(c);
            in_data = {$urandom, $urandom};
            in_addr = {$urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (acc.size() >= 2) chk("b2b_spacing", 64'(acc[1] - acc[0]), 64'd2);
        else chk("b2b_accept_count", 64'(acc.size()), 64'd2);
        repeat (2) @(negedge clk);

        // Randomised traffic with occasional reset pulses.
        hold = 0;
        for (int it = 0; it < 600; it++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (hold > 0) begin
                in_valid = 1'b0;
                hold--;
            end else if ($urandom_range(0, 149) == 0) begin
                in_valid = 1'b0;
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                hold = 2;
            end else begin
                in_valid = $urandom_range(0, 1) == 1;
                in_size  = 2'($urandom_range(0, 3));
                d = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1) d = sext(d, 1 << in_size);
                in_data = d;
                if ($urandom_range(0, 3) == 0) in_addr = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
                else in_addr = {$urandom, $urandom};
            end
            @(negedge clk);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_narrower.md
STORE_NARROWER -- requirements
Module: store_narrower

Interface
REQ-001 Parameter: ADDR_W, 64, width of address input and output.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset is asserted while low.
REQ-004 in_valid  input  1  store request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_data  input  64  store value, in sign-extended register form.
REQ-007 in_addr  input  ADDR_W  byte address of the lowest byte.
REQ-008 in_size  input  2  transfer size: 0=byte, 1=half, 2=word, 3=double.
REQ-009 out_valid  output  1  byte beat present.
REQ-010 out_ready  input  1  sink accepts the beat.
REQ-011 out_byte  output  8  current byte of the store.
REQ-012 out_addr  output  ADDR_W  address of the current byte.
REQ-013 out_last  output  1  current beat is the final byte of the request.
REQ-014 fits  output  1  the latched value is exactly representable in the requested width.

Function
REQ-015 The block SHALL have two states: IDLE and SEND.
REQ-016 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is SEND.
REQ-017 A request is accepted when in_valid=1 and in_ready=1. On acceptance the block SHALL latch in_data, in_addr and in_size, clear the beat index to 0, and enter SEND on the next edge.
REQ-018 Beat count N SHALL be 1, 2, 4 or 8 for in_size 0, 1, 2 or 3.
REQ-019 Byte order is little-endian: out_byte = data[8*idx+7 : 8*idx] and out_addr = base + idx, where idx is the beat index.
REQ-020 out_addr arithmetic SHALL be modulo 2^ADDR_W; the address wraps through zero without error.
REQ-021 The beat index SHALL advance only when out_valid=1 and out_ready=1. While out_ready=0, out_byte, out_addr and out_last SHALL hold stable.
REQ-022 out_last SHALL be 1 exactly when idx = N-1.
REQ-023 A handshake on the last beat SHALL return the block to IDLE on the next edge.
REQ-024 No new request is accepted in the same cycle as the last beat; the minimum spacing between acceptances is N+1 cycles.
REQ-025 fits SHALL be computed at acceptance and held until the next acceptance.
REQ-026 fits=1 when all bits in_data[63 : 8N-1] are equal; for in_size=3, fits is always 1.
REQ-027 fits is informational only and SHALL NOT alter the transfer.
REQ-028 Latency: the first beat SHALL be valid in the cycle after acceptance.
REQ-029 in_data, in_addr and in_size SHALL be ignored while in SEND.

Reset
REQ-030 While reset is low, the state SHALL be IDLE.
REQ-031 While reset is low, idx, data, base, size and fits SHALL all be 0; out_valid=0 and in_ready=1.
REQ-032 Reset asserted mid-SEND SHALL abort the transfer immediately; no further beats are emitted after reset releases.
REQ-033 Reset release SHALL be synchronised internally, so the first acceptance is possible no earlier than the second edge after release.

Structure
REQ-034 A shared package SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE), the state enum, and a function mapping size to beat count.
REQ-035 There SHALL be one combinational sub-module, fit_checker, with inputs value (64) and size (2) and output fits (1).
REQ-036 fit_checker SHALL be the exact inverse check of sign extension to 64 bits.

Verification
REQ-037 Byte store: data=0xFFFF_FFFF_FFFF_FF80, size=0, addr=0x100 -> one beat with out_byte=0x80, out_addr=0x100, out_last=1, fits=1.
REQ-038 Word store: data=0x0000_0000_1234_5678, size=2, addr=0x20 -> beats 0x78, 0x56, 0x34, 0x12 at 0x20..0x23, out_last only on the fourth, fits=1.
REQ-039 Overflow: data=0x0000_0000_0000_0080, size=0 -> out_byte=0x80, fits=0.
REQ-040 Back-pressure plus wrap: size=1, addr=0xFFFF_FFFF_FFFF_FFFF, out_ready=0 for 3 cycles -> beat 0 held stable, then beat 1 at out_addr=0x0.
REQ-041 Reset mid-transfer: reset low during beat 3 of a size=3 store -> out_valid=0 and in_ready=1 while low; no residual beats after release.
REQ-042 Back-to-back: in_valid held high across two size=0 requests -> acceptances exactly 2 cycles apart.
